// File: rtl/rx_frame_pkg.sv
// Shared definitions for the receive deframer and the link CRC path:
// sync constants, CRC-16 parameters, FSM states and error bit positions.
package rx_frame_pkg;

  localparam logic [7:0]  SYNC0_BYTE = 8'hEB;
  localparam logic [7:0]  SYNC1_BYTE = 8'h90;
  localparam logic [15:0] CRC_POLY   = 16'h8005;
  localparam logic [15:0] CRC_INIT   = 16'hFFFF;

  // Bit positions inside the 3-bit error pulse {timeout, len_err, idenf_err}
  localparam int ERR_IDENF   = 0;
  localparam int ERR_LEN     = 1;
  localparam int ERR_TIMEOUT = 2;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_SYNC1,
    ST_IDENF,
    ST_TYPE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CRC_H,
    ST_CRC_L
  } state_t;

  // Saturating 16-bit increment used by the frame counters
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

endpackage

// File: rtl/crc16_byte_upd.sv
// One-byte step of the link CRC-16 (poly 0x8005, MSB-first, no reflection).
// Purely combinational so the TX and RX paths can share it.
module crc16_byte_upd
  import rx_frame_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data_byte,
  output logic [15:0] crc_out
);

  // Shift the byte through the CRC register one bit at a time, MSB first
  always_comb begin
    logic [15:0] c;
    c = crc_in;
    for (int i = 7; i >= 0; i--) begin
      if (c[15] ^ data_byte[i]) begin
        c = {c[14:0], 1'b0} ^ CRC_POLY;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
    crc_out = c;
  end

endmodule

// File: rtl/rx_frame_parser.sv
// Receive-side deframer: hunts the two-byte sync, checks the ident,
// latches the para type, streams the payload, verifies the CRC-16 and
// keeps saturating good/error frame counters.
module rx_frame_parser
  import rx_frame_pkg::*;
#(
  parameter int         MAX_LEN     = 64,
  parameter int         TIMEOUT_CYC = 4096,
  parameter logic [7:0] SYNC0       = SYNC0_BYTE,
  parameter logic [7:0] SYNC1       = SYNC1_BYTE
) (
  input  logic        clk163m84,
  input  logic        rst_n,
  input  logic [7:0]  info_unit_idenf_i,
  input  logic [7:0]  i_data_in,
  input  logic        i_data_valid,
  output logic [7:0]  o_data_out,
  output logic        o_data_valid,
  output logic        o_sof,
  output logic        o_eof,
  output logic [7:0]  o_para_type,
  output logic        o_frame_done,
  output logic        o_crc_ok,
  output logic [2:0]  o_err,
  output logic [15:0] o_good_cnt,
  output logic [15:0] o_err_cnt
);

  localparam int               GAP_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

  state_t           state;
  logic [15:0]      crc_r;
  logic [15:0]      crc_next;
  logic [7:0]       crc_hi_r;
  logic [7:0]       rem_r;
  logic             first_r;
  logic [GAP_W-1:0] gap_r;
  logic [15:0]      good_cnt_r;
  logic [15:0]      err_cnt_r;

  assign o_good_cnt = good_cnt_r;
  assign o_err_cnt  = err_cnt_r;

  crc16_byte_upd u_crc (
    .crc_in    (crc_r),
    .data_byte (i_data_in),
    .crc_out   (crc_next)
  );

  // Frame FSM, idle-gap watchdog, registered outputs and counters
  always_ff @(posedge clk163m84) begin
    if (!rst_n) begin
      state        <= ST_HUNT;
      crc_r        <= CRC_INIT;
      crc_hi_r     <= 8'd0;
      rem_r        <= 8'd0;
      first_r      <= 1'b0;
      gap_r        <= '0;
      good_cnt_r   <= 16'd0;
      err_cnt_r    <= 16'd0;
      o_data_out   <= 8'd0;
      o_data_valid <= 1'b0;
      o_sof        <= 1'b0;
      o_eof        <= 1'b0;
      o_para_type  <= 8'd0;
      o_frame_done <= 1'b0;
      o_crc_ok     <= 1'b0;
      o_err        <= 3'b000;
    end else begin
      o_data_valid <= 1'b0;
      o_sof        <= 1'b0;
      o_eof        <= 1'b0;
      o_frame_done <= 1'b0;
      o_crc_ok     <= 1'b0;
      o_err        <= 3'b000;

      if (i_data_valid) begin
        // A byte always wins over a watchdog expiry in the same cycle
        gap_r <= '0;
        case (state)
          ST_HUNT: begin
            if (i_data_in == SYNC0) begin
              state <= ST_SYNC1;
            end else begin
              state <= ST_HUNT;
            end
          end
          ST_SYNC1: begin
            if (i_data_in == SYNC1) begin
              state <= ST_IDENF;
              crc_r <= CRC_INIT;
            end else if (i_data_in == SYNC0) begin
              state <= ST_SYNC1;
            end else begin
              state <= ST_HUNT;
            end
          end
          ST_IDENF: begin
            if (i_data_in == info_unit_idenf_i) begin
              state <= ST_TYPE;
              crc_r <= crc_next;
            end else begin
              state            <= ST_HUNT;
              o_err[ERR_IDENF] <= 1'b1;
              err_cnt_r        <= sat_inc16(err_cnt_r);
            end
          end
          ST_TYPE: begin
            o_para_type <= i_data_in;
            crc_r       <= crc_next;
            state       <= ST_LEN;
          end
          ST_LEN: begin
            if ((i_data_in == 8'd0) || (i_data_in > MAX_LEN_B)) begin
              state          <= ST_HUNT;
              o_err[ERR_LEN] <= 1'b1;
              err_cnt_r      <= sat_inc16(err_cnt_r);
            end else begin
              rem_r   <= i_data_in;
              first_r <= 1'b1;
              crc_r   <= crc_next;
              state   <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            // Sync patterns here are plain data; no resync mid-frame
            o_data_out   <= i_data_in;
            o_data_valid <= 1'b1;
            o_sof        <= first_r;
            o_eof        <= (rem_r == 8'd1);
            first_r      <= 1'b0;
            rem_r        <= rem_r - 8'd1;
            crc_r        <= crc_next;
            if (rem_r == 8'd1) begin
              state <= ST_CRC_H;
            end else begin
              state <= ST_PAYLOAD;
            end
          end
          ST_CRC_H: begin
            crc_hi_r <= i_data_in;
            state    <= ST_CRC_L;
          end
          ST_CRC_L: begin
            state        <= ST_HUNT;
            o_frame_done <= 1'b1;
            if ({crc_hi_r, i_data_in} == crc_r) begin
              o_crc_ok   <= 1'b1;
              good_cnt_r <= sat_inc16(good_cnt_r);
            end else begin
              o_crc_ok  <= 1'b0;
              err_cnt_r <= sat_inc16(err_cnt_r);
            end
          end
          default: begin
            state <= ST_HUNT;
          end
        endcase
      end else if (state != ST_HUNT) begin
        if (gap_r == GAP_LAST) begin
          state              <= ST_HUNT;
          gap_r              <= '0;
          o_err[ERR_TIMEOUT] <= 1'b1;
          err_cnt_r          <= sat_inc16(err_cnt_r);
        end else begin
          gap_r <= gap_r + GAP_W'(1);
        end
      end else begin
        gap_r <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rx_frame_parser.sv
// Self-checking bench for rx_frame_parser: directed frames plus a random
// frame loop, each frame's expected outcome derived from how it was built.
module tb_rx_frame_parser;

  localparam int MAX_LEN = 64;
  localparam int TO      = 4096;
  localparam int K_GOOD   = 0;
  localparam int K_BADCRC = 1;
  localparam int K_BADID  = 2;
  localparam int K_BADLEN = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  idenf;
  logic [7:0]  i_data_in;
  logic        i_data_valid;
  logic [7:0]  o_data_out;
  logic        o_data_valid, o_sof, o_eof, o_frame_done, o_crc_ok;
  logic [7:0]  o_para_type;
  logic [2:0]  o_err;
  logic [15:0] o_good_cnt, o_err_cnt;

  logic [15:0] u_crc_in, u_crc_out;
  logic [7:0]  u_crc_byte;

  always #3 clk = ~clk;

  rx_frame_parser #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TO)) dut (
    .clk163m84(clk), .rst_n(rst_n), .info_unit_idenf_i(idenf),
    .i_data_in(i_data_in), .i_data_valid(i_data_valid),
    .o_data_out(o_data_out), .o_data_valid(o_data_valid),
    .o_sof(o_sof), .o_eof(o_eof), .o_para_type(o_para_type),
    .o_frame_done(o_frame_done), .o_crc_ok(o_crc_ok), .o_err(o_err),
    .o_good_cnt(o_good_cnt), .o_err_cnt(o_err_cnt)
  );

  crc16_byte_upd u_crc (.crc_in(u_crc_in), .data_byte(u_crc_byte), .crc_out(u_crc_out));

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  exp_type;
  logic [15:0] exp_good, exp_errc;
  logic [7:0]  pay_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [15:0] bump(input logic [15:0] v);
    int t;
    t = int'(v) + 1;
    return (t > 65535) ? 16'hFFFF : 16'(t);
  endfunction

  // Whole-message bit-serial CRC over the message bytes
  function automatic logic [15:0] crc_ref(input logic [7:0] msg[$]);
    int acc;
    int top;
    acc = 32'h0000FFFF;
    foreach (msg[j]) begin
      for (int k = 7; k >= 0; k--) begin
        top = ((acc >> 15) & 1) ^ ((int'(msg[j]) >> k) & 1);
        acc = (acc << 1) & 32'h0000FFFF;
        if (top != 0) acc = acc ^ 32'h00008005;
      end
    end
    return 16'(acc);
  endfunction

  task automatic send_byte(input logic [7:0] b);
    i_data_in    = b;
    i_data_valid = 1'b1;
    @(posedge clk);
    #1;
    i_data_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_dv"},   o_data_valid, 0);
    chk({tag, "_data"}, o_data_out, 0);
    chk({tag, "_sof"},  o_sof, 0);
    chk({tag, "_eof"},  o_eof, 0);
    chk({tag, "_type"}, o_para_type, 0);
    chk({tag, "_done"}, o_frame_done, 0);
    chk({tag, "_ok"},   o_crc_ok, 0);
    chk({tag, "_err"},  o_err, 0);
    chk({tag, "_good"}, o_good_cnt, 0);
    chk({tag, "_errc"}, o_err_cnt, 0);
  endtask

  // cut_mode: 0 none, 1 stall stall_len idle clocks after byte cut_idx, 2 reset after byte cut_idx
  task automatic run_frame(input string tag, input int kind, input int n_eb,
                           input logic [7:0] ptype, input logic [7:0] len_byte,
                           input int cut_mode, input int cut_idx, input int stall_len);
    logic [7:0]  fr[$];
    int          pidx[$];
    logic [7:0]  msg[$];
    logic [15:0] c;
    int          npay;
    npay = pay_q.size();
    repeat (n_eb) begin fr.push_back(8'hEB); pidx.push_back(-1); end
    fr.push_back(8'h90); pidx.push_back(-1);
    if (kind == K_BADID) begin
      fr.push_back(idenf ^ 8'hFF); pidx.push_back(-1);
    end else begin
      fr.push_back(idenf);    pidx.push_back(-1);
      fr.push_back(ptype);    pidx.push_back(-1);
      fr.push_back(len_byte); pidx.push_back(-1);
      if (kind != K_BADLEN) begin
        msg.push_back(idenf); msg.push_back(ptype); msg.push_back(len_byte);
        for (int p = 0; p < npay; p++) begin
          fr.push_back(pay_q[p]); pidx.push_back(p); msg.push_back(pay_q[p]);
        end
        c = crc_ref(msg);
        fr.push_back(c[15:8]); pidx.push_back(-1);
        fr.push_back(c[7:0] ^ ((kind == K_BADCRC) ? 8'h01 : 8'h00)); pidx.push_back(-1);
      end
    end

    for (int i = 0; i < fr.size(); i++) begin
      send_byte(fr[i]);
      if (pidx[i] >= 0) begin
        chk({tag, "_dv"},   o_data_valid, 1);
        chk({tag, "_data"}, o_data_out, pay_q[pidx[i]]);
        chk({tag, "_sof"},  o_sof, (pidx[i] == 0) ? 1 : 0);
        chk({tag, "_eof"},  o_eof, (pidx[i] == npay - 1) ? 1 : 0);
      end else begin
        chk({tag, "_nodv"}, o_data_valid, 0);
      end
      if (cut_mode != 0 && i == cut_idx) begin
        if (cut_mode == 2) begin
          rst_n = 1'b0;
          idle(1);
          check_all_zero({tag, "_rst"});
          rst_n    = 1'b1;
          exp_good = 16'd0;
          exp_errc = 16'd0;
          exp_type = 8'd0;
          return;
        end else if (stall_len >= TO) begin
          idle(TO - 1);
          chk({tag, "_to_early"}, o_err, 3'b000);
          idle(1);
          exp_errc = bump(exp_errc);
          chk({tag, "_to_pulse"}, o_err, 3'b100);
          chk({tag, "_to_done"},  o_frame_done, 0);
          chk({tag, "_to_errc"},  o_err_cnt, exp_errc);
          chk({tag, "_to_eof"},   o_eof, 0);
          idle(1);
          chk({tag, "_to_clr"},   o_err, 3'b000);
          return;
        end else begin
          idle(stall_len);
          chk({tag, "_gap_err"}, o_err, 3'b000);
        end
      end
    end

    if (kind != K_BADID) exp_type = ptype;
    if (kind == K_GOOD) exp_good = bump(exp_good);
    else                exp_errc = bump(exp_errc);
    chk({tag, "_done"}, o_frame_done, (kind == K_GOOD || kind == K_BADCRC) ? 1 : 0);
    chk({tag, "_ok"},   o_crc_ok, (kind == K_GOOD) ? 1 : 0);
    chk({tag, "_err"},  o_err, (kind == K_BADID) ? 3'b001 : (kind == K_BADLEN) ? 3'b010 : 3'b000);
    chk({tag, "_good"}, o_good_cnt, exp_good);
    chk({tag, "_errc"}, o_err_cnt, exp_errc);
    chk({tag, "_type"}, o_para_type, exp_type);
    idle(1);
    chk({tag, "_q_done"}, o_frame_done, 0);
    chk({tag, "_q_err"},  o_err, 0);
    chk({tag, "_q_dv"},   o_data_valid, 0);
  endtask

  task automatic rand_pay(input int n);
    pay_q.delete();
    for (int p = 0; p < n; p++) pay_q.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    string s;
    int    kind;
    int    len;
    s = "123456789";
    rst_n        = 1'b0;
    i_data_valid = 1'b0;
    i_data_in    = 8'h00;
    idenf        = 8'($urandom_range(0, 255));
    exp_type     = 8'd0;
    exp_good     = 16'd0;
    exp_errc     = 16'd0;

    u_crc_in   = 16'hFFFF;
    u_crc_byte = 8'h00;
    for (int i = 0; i < s.len(); i++) begin
      u_crc_byte = s[i];
      #1;
      u_crc_in = u_crc_out;
    end
    chk("crc_unit", u_crc_in, 16'hAEE7);

    idle(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    idle(2);

    pay_q = '{8'h11, 8'h22, 8'h33};
    run_frame("good", K_GOOD, 1, 8'h05, 8'd3, 0, 0, 0);
    run_frame("badcrc", K_BADCRC, 1, 8'h06, 8'd3, 0, 0, 0);
    rand_pay(5);
    run_frame("eb_eb", K_GOOD, 2, 8'h21, 8'd5, 0, 0, 0);
    run_frame("len0", K_BADLEN, 1, 8'h22, 8'd0, 0, 0, 0);
    run_frame("len_big", K_BADLEN, 1, 8'h23, 8'(MAX_LEN + 1), 0, 0, 0);
    pay_q = '{8'hEB, 8'h90, 8'hEB, 8'h90};
    run_frame("sync_in_pay", K_GOOD, 1, 8'h24, 8'd4, 0, 0, 0);
    run_frame("bad_id", K_BADID, 1, 8'h00, 8'd0, 0, 0, 0);
    rand_pay(1);
    run_frame("len1", K_GOOD, 1, 8'h25, 8'd1, 0, 0, 0);
    rand_pay(MAX_LEN);
    run_frame("len_max", K_GOOD, 1, 8'h26, 8'(MAX_LEN), 0, 0, 0);

    rand_pay(4);
    run_frame("timeout", K_GOOD, 1, 8'h27, 8'd4, 1, 6, TO);
    rand_pay(4);
    run_frame("after_to", K_GOOD, 1, 8'h28, 8'd4, 0, 0, 0);
    rand_pay(4);
    run_frame("gap_short", K_GOOD, 1, 8'h29, 8'd4, 1, 6, TO - 1);

    rand_pay(4);
    run_frame("mid_rst", K_GOOD, 1, 8'h2A, 8'd4, 2, 6, 0);
    rand_pay(3);
    run_frame("after_rst", K_GOOD, 1, 8'h2B, 8'd3, 0, 0, 0);

    for (int r = 0; r < 20; r++) begin
      kind = ($urandom_range(0, 9) < 6) ? K_GOOD : int'($urandom_range(1, 3));
      len  = $urandom_range(1, MAX_LEN);
      rand_pay(len);
      if (kind == K_BADLEN) begin
        len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAX_LEN + 1, 255);
      end
      run_frame("rand", kind, $urandom_range(1, 3), 8'($urandom_range(0, 255)), 8'(len), 0, 0, 0);
    end

    force dut.good_cnt_r = 16'hFFFE;
    #1;
    release dut.good_cnt_r;
    exp_good = 16'hFFFE;
    chk("sat_preload", o_good_cnt, 16'hFFFE);
    rand_pay(2);
    run_frame("sat1", K_GOOD, 1, 8'h31, 8'd2, 0, 0, 0);
    rand_pay(2);
    run_frame("sat2", K_GOOD, 1, 8'h32, 8'd2, 0, 0, 0);
    chk("sat_hold", o_good_cnt, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
